// File: rtl/clk_duty_meter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_duty_meter_pkg : FSM state type and scaling constants for clk_duty_meter
// Rev 1.0
// ---------------------------------------------------------------------------
package clk_duty_meter_pkg;

  localparam int PCT_SCALE = 100;
  localparam int Q_W       = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_RISE = 3'd1,
    ST_MEAS_HIGH = 3'd2,
    ST_MEAS_LOW  = 3'd3,
    ST_CALC      = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/clk_duty_meter_duty_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// duty_div : 7-iteration restoring divider, quotient of high*100 / period
// Rev 1.0
// ---------------------------------------------------------------------------
module duty_div
  import clk_duty_meter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [CNT_W+Q_W-1:0]   i_dividend,
  input  logic [CNT_W-1:0]       i_divisor,
  output logic [Q_W-1:0]         o_quot,
  output logic                   o_done
);

  localparam int DW = CNT_W + Q_W;

  logic [DW-1:0]  r_rem, r_dsr;
  logic [DW-1:0]  w_rem, w_dsr, w_diff;
  logic [Q_W-1:0] r_quot, w_quot_in;
  logic [2:0]     r_cnt;
  logic           r_busy, r_done;
  logic           w_ge;

  // The first iteration runs on the start cycle itself, so the last
  // quotient bit is registered exactly Q_W-1 cycles after start.
  assign w_rem     = i_start ? i_dividend : r_rem;
  assign w_dsr     = i_start ? {1'b0, i_divisor, {(Q_W-1){1'b0}}} : r_dsr;
  assign w_quot_in = i_start ? '0 : r_quot;
  assign w_ge      = (w_rem >= w_dsr);
  assign w_diff    = w_rem - w_dsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_dsr  <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start || r_busy) begin
        r_rem  <= w_ge ? w_diff : w_rem;
        r_quot <= {w_quot_in[Q_W-2:0], w_ge};
        r_dsr  <= w_dsr >> 1;
        if (i_start) begin
          r_cnt  <= 3'(Q_W - 1);
          r_busy <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
      end
    end
  end

  assign o_quot = r_quot;
  assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/clk_duty_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_duty_meter : measures period and high time of sig_in in clk cycles;
// duty percentage only when CLK_DUTY_METER_DUTY_PCT_EN is defined.  Rev 1.0
// ---------------------------------------------------------------------------
module clk_duty_meter
  import clk_duty_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [Q_W-1:0]   duty_pct,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] c_one    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_sat_m1 = {{(CNT_W-1){1'b1}}, 1'b0};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic                   w_sync, w_rise, w_fall, w_ovf_hit;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_period, r_high, r_wait;
  logic [CNT_W-1:0]       r_period_o, r_high_o;
  logic [Q_W-1:0]         r_duty;
  logic                   r_busy, r_done, r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_sync_d <= w_sync;
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_sync_d;
  assign w_fall = ~w_sync & r_sync_d;

  // The counter would reach all-ones this cycle: abort the measurement.
  assign w_ovf_hit = ((r_state == ST_WAIT_RISE) && !w_rise && (r_wait == c_sat_m1)) ||
                     ((r_state == ST_MEAS_HIGH) && (r_period == c_sat_m1)) ||
                     ((r_state == ST_MEAS_LOW) && !w_rise && (r_period == c_sat_m1));

`ifdef CLK_DUTY_METER_DUTY_PCT_EN
  localparam logic [CNT_W+Q_W-1:0] c_scale = (CNT_W+Q_W)'(PCT_SCALE);

  logic                   w_div_start, w_div_done;
  logic [CNT_W+Q_W-1:0]   w_dividend;
  logic [Q_W-1:0]         w_quot;

  assign w_div_start = (r_state == ST_MEAS_LOW) && w_rise;
  assign w_dividend  = {{Q_W{1'b0}}, r_high} * c_scale;

  duty_div #(.CNT_W(CNT_W)) u_duty_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (w_dividend),
    .i_divisor  (r_period),
    .o_quot     (w_quot),
    .o_done     (w_div_done)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_period   <= '0;
      r_high     <= '0;
      r_wait     <= '0;
      r_period_o <= '0;
      r_high_o   <= '0;
      r_duty     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_ovf_hit) begin
        r_state    <= ST_DONE;
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
        r_overflow <= 1'b1;
        r_period_o <= '1;
        r_high_o   <= '1;
        r_duty     <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (start) begin
            r_state    <= ST_WAIT_RISE;
            r_busy     <= 1'b1;
            r_overflow <= 1'b0;
            r_wait     <= '0;
          end
          ST_WAIT_RISE: if (w_rise) begin
            r_state  <= ST_MEAS_HIGH;
            r_period <= c_one;
            r_high   <= c_one;
          end else begin
            r_wait <= r_wait + c_one;
          end
          ST_MEAS_HIGH: begin
            r_period <= r_period + c_one;
            if (w_fall) r_state <= ST_MEAS_LOW;
            else        r_high  <= r_high + c_one;
          end
          ST_MEAS_LOW: if (w_rise) begin
`ifdef CLK_DUTY_METER_DUTY_PCT_EN
            r_state <= ST_CALC;
`else
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_period_o <= r_period;
            r_high_o   <= r_high;
            r_duty     <= '0;
`endif
          end else begin
            r_period <= r_period + c_one;
          end
          ST_CALC: begin
`ifdef CLK_DUTY_METER_DUTY_PCT_EN
            if (w_div_done) begin
              r_state    <= ST_DONE;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_period_o <= r_period;
              r_high_o   <= r_high;
              r_duty     <= w_quot;
            end
`else
            r_state <= ST_IDLE;
`endif
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign period_cnt = r_period_o;
  assign high_cnt   = r_high_o;
  assign duty_pct   = r_duty;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_clk_duty_meter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_clk_duty_meter : directed stimulus with a cycle-exact reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_clk_duty_meter;

  localparam int CNT_W = 8;
  localparam int SAT   = 255;
  localparam int BIG   = 32'h3fff_ffff;
`ifdef CLK_DUTY_METER_DUTY_PCT_EN
  localparam int LAT    = 7;
  localparam bit PCT_EN = 1'b1;
`else
  localparam int LAT    = 0;
  localparam bit PCT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, sig_in, start;
  logic             busy, done, overflow;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic [6:0]       duty_pct;

  clk_duty_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .duty_pct   (duty_pct),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  // Reference model: pending result plus the values the outputs must hold.
  bit m_active = 1'b0;
  int m_busy_from = -1, m_done_cyc = -1, m_rst_cyc = -1;
  int m_p_per, m_p_high, m_p_duty, m_p_ovf;
  int m_per = 0, m_high = 0, m_duty = 0, m_ovf = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int exp_duty(input int p, input int h);
    return PCT_EN ? (h * 100) / p : 0;
  endfunction

  always @(negedge clk) begin
    if (m_active) begin
      if (cyc == m_rst_cyc) begin
        m_per = 0; m_high = 0; m_duty = 0; m_ovf = 0;
        m_done_cyc = -1; m_busy_from = -1;
      end
      if (cyc == m_busy_from) m_ovf = 0;
      if (cyc == m_done_cyc) begin
        m_per = m_p_per; m_high = m_p_high; m_duty = m_p_duty; m_ovf = m_p_ovf;
      end
      chk("done", int'(done), int'(cyc == m_done_cyc));
      chk("busy", int'(busy), int'(m_busy_from >= 0 && cyc >= m_busy_from && cyc < m_done_cyc));
      chk("period_cnt", int'(period_cnt), m_per);
      chk("high_cnt", int'(high_cnt), m_high);
      chk("duty_pct", int'(duty_pct), m_duty);
      chk("overflow", int'(overflow), m_ovf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start       = 1'b1;
    m_busy_from = cyc + 1;
    m_done_cyc  = BIG;
    tick();
    start = 1'b0;
  endtask

  task automatic set_pending(input int p, input int h, input int d, input int o);
    m_p_per = p; m_p_high = h; m_p_duty = d; m_p_ovf = o;
  endtask

  // One full measurement of a p-cycle period with h cycles high; noisy adds
  // ignored start pulses in WAIT_RISE, just before done and on the done cycle.
  task automatic measure(input int p, input int h, input int pre, input bit noisy);
    int r1, k;
    pulse_start();
    repeat (pre) tick();
    r1     = cyc;
    sig_in = 1'b1;
    set_pending(p, h, exp_duty(p, h), 0);
    m_done_cyc = r1 + p + 3 + LAT;
    do begin
      tick();
      k      = cyc - r1;
      sig_in = (k < h) || (k >= p && k < p + h);
      start  = noisy && (k == 1 || cyc == m_done_cyc - 1 || cyc == m_done_cyc);
    end while (cyc < m_done_cyc + 2 || cyc < r1 + p + h + 4);
    start = 1'b0;
  endtask

  task automatic wait_ovf();
    sig_in = 1'b0;
    pulse_start();
    set_pending(SAT, SAT, 0, 1);
    m_done_cyc = cyc + SAT;
    while (cyc < m_done_cyc + 2) tick();
  endtask

  task automatic meas_ovf();
    int r1;
    pulse_start();
    repeat (2) tick();
    r1     = cyc;
    sig_in = 1'b1;
    set_pending(SAT, SAT, 0, 1);
    m_done_cyc = r1 + 2 + SAT;
    while (cyc < m_done_cyc + 2) tick();
    sig_in = 1'b0;
    repeat (4) tick();
  endtask

  task automatic reset_in_meas_low();
    int r1;
    pulse_start();
    repeat (3) tick();
    r1     = cyc;
    sig_in = 1'b1;
    set_pending(20, 14, exp_duty(20, 14), 0);
    m_done_cyc = r1 + 23 + LAT;
    for (int k = 1; k <= 18; k++) begin
      tick();
      sig_in = (cyc - r1) < 14;
    end
    rst       = 1'b1;
    m_rst_cyc = cyc + 1;
    tick();
    rst    = 1'b0;
    sig_in = 1'b0;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_period", int'(period_cnt), 0);
    repeat (30) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sig_in = 1'b0; start = 1'b0;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_period", int'(period_cnt), 0);
    chk("rst_overflow", int'(overflow), 0);
    rst      = 1'b0;
    m_active = 1'b1;
    tick();

    measure(20, 14, 3, 1'b0);
    chk("lit_20_period", int'(period_cnt), 20);
    chk("lit_20_high", int'(high_cnt), 14);
    chk("lit_20_duty", int'(duty_pct), PCT_EN ? 70 : 0);

    measure(3, 1, 2, 1'b0);
    chk("lit_3_period", int'(period_cnt), 3);
    chk("lit_3_high", int'(high_cnt), 1);
    chk("lit_3_duty", int'(duty_pct), PCT_EN ? 33 : 0);

    measure(20, 14, 1, 1'b1);
    measure(2, 1, 2, 1'b0);
    measure(254, 100, 2, 1'b0);
    chk("lit_254_duty", int'(duty_pct), PCT_EN ? 39 : 0);

    wait_ovf();
    chk("lit_wait_ovf", int'(overflow), 1);
    chk("lit_wait_period", int'(period_cnt), 255);
    chk("lit_wait_duty", int'(duty_pct), 0);

    measure(10, 5, 2, 1'b0);
    chk("lit_ovf_cleared", int'(overflow), 0);
    chk("lit_10_duty", int'(duty_pct), PCT_EN ? 50 : 0);

    meas_ovf();
    chk("lit_meas_ovf_high", int'(high_cnt), 255);

    reset_in_meas_low();
    measure(20, 14, 3, 1'b0);
    chk("lit_post_rst_period", int'(period_cnt), 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
